// File: rtl/ex_serial_stage_pkg.sv
// Purpose : shared constants, types and the shift helper for the EX stage slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: aluop/alusel encodings, shifter FSM states, ex_mem payload struct.
package ex_serial_stage_pkg;

  typedef logic [7:0] aluop_t;
  typedef logic [2:0] alusel_t;

  // Operation encodings shared with the decoder.
  localparam aluop_t EXE_NOP_OP = 8'b0000_0000;
  localparam aluop_t EXE_AND_OP = 8'b0010_0100;
  localparam aluop_t EXE_OR_OP  = 8'b0010_0101;
  localparam aluop_t EXE_XOR_OP = 8'b0010_0110;
  localparam aluop_t EXE_NOR_OP = 8'b0010_0111;
  localparam aluop_t EXE_LUI_OP = 8'b0101_1100;
  localparam aluop_t EXE_SLL_OP = 8'b0111_1100;
  localparam aluop_t EXE_SRL_OP = 8'b0000_0010;
  localparam aluop_t EXE_SRA_OP = 8'b0000_0011;

  localparam alusel_t EXE_RES_NOP   = 3'b000;
  localparam alusel_t EXE_RES_LOGIC = 3'b001;
  localparam alusel_t EXE_RES_SHIFT = 3'b010;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;

  typedef enum logic [1:0] {
    SHIFT_IDLE = 2'd0,
    SHIFT_RUN  = 2'd1,
    SHIFT_DONE = 2'd2
  } shift_state_e;

  // Payload held in the ex_mem register.
  typedef struct packed {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } wb_t;

  // One barrel-shift step; right shifts optionally sign-fill.
  function automatic logic [31:0] shift_by(input logic [31:0] v, input logic [4:0] amt,
                                           input logic dir_right, input logic arith);
    if (!dir_right) return v << amt;
    else if (arith) return $unsigned($signed(v) >>> amt);
    else            return v >> amt;
  endfunction

endpackage

// File: rtl/ex_serial_stage_if.sv
// Purpose : id_ex operation bundle handed from the decoder pipeline register to EX.
// Latency : n/a (wires only).
// Backpressure: none here; the bundle is held stable upstream while EX stalls.
// Signals : aluop, alusel, reg1, reg2, wd, wreg. master = id_ex side, slave = EX side.
interface ex_serial_stage_if;
  import ex_serial_stage_pkg::*;

  aluop_t      aluop;
  alusel_t     alusel;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        wreg;

  modport master (output aluop, alusel, reg1, reg2, wd, wreg);
  modport slave  (input  aluop, alusel, reg1, reg2, wd, wreg);
endinterface

// File: rtl/ex_serial_stage_shifter.sv
// Purpose : multi-cycle shifter moving SHIFT_STEP bits per cycle (module ex_serial_shifter).
// Latency : 0 cycles if amount <= SHIFT_STEP, else ceil(amount/SHIFT_STEP)-1 busy cycles.
// Backpressure: hold_i parks a finished result in DONE; abort_i returns to IDLE next cycle.
// Ports   : clk, rst, start_i, dir_i (1=right), arith_i, amount_i, value_i, hold_i, abort_i
//           -> busy_o, result_o.
module ex_serial_shifter
  import ex_serial_stage_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        dir_i,
  input  logic        arith_i,
  input  logic [4:0]  amount_i,
  input  logic [31:0] value_i,
  input  logic        hold_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic [31:0] result_o
);

  // 6-bit step so that SHIFT_STEP=32 compares correctly; the 5-bit amount
  // form is only used on paths that STEP=32 can never reach.
  localparam logic [5:0] STEP_W   = 6'(SHIFT_STEP);
  localparam logic [4:0] STEP_AMT = 5'(SHIFT_STEP % 32);

  shift_state_e state_q, state_d;
  logic [31:0]  acc_q, acc_d;
  logic [4:0]   rem_q, rem_d;

  logic        long_start;
  logic        rem_gt_step;
  logic [31:0] step_from_in;
  logic [31:0] step_from_acc;
  logic [31:0] finish_val;

  assign long_start    = start_i && ({1'b0, amount_i} > STEP_W);
  assign rem_gt_step   = {1'b0, rem_q} > STEP_W;
  assign step_from_in  = shift_by(value_i, STEP_AMT, dir_i, arith_i);
  assign step_from_acc = shift_by(acc_q, STEP_AMT, dir_i, arith_i);
  assign finish_val    = shift_by(acc_q, rem_q, dir_i, arith_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHIFT_IDLE;
      acc_q   <= ZERO_WORD;
      rem_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      SHIFT_IDLE: begin
        if (long_start) begin
          state_d = SHIFT_RUN;
          acc_d   = step_from_in;
          rem_d   = amount_i - STEP_AMT;
        end
      end
      SHIFT_RUN: begin
        if (rem_gt_step) begin
          acc_d = step_from_acc;
          rem_d = rem_q - STEP_AMT;
        end else if (hold_i) begin
          // Park the final value so acc alone drives the result while held.
          state_d = SHIFT_DONE;
          acc_d   = finish_val;
        end else begin
          state_d = SHIFT_IDLE;
        end
      end
      SHIFT_DONE: begin
        if (!hold_i) state_d = SHIFT_IDLE;
      end
      default: state_d = SHIFT_IDLE;
    endcase
    if (abort_i) begin
      state_d = SHIFT_IDLE;
      rem_d   = 5'd0;
    end
  end

  always_comb begin
    busy_o   = 1'b0;
    result_o = ZERO_WORD;
    case (state_q)
      SHIFT_IDLE: begin
        if (long_start)   busy_o   = 1'b1;
        else if (start_i) result_o = shift_by(value_i, amount_i, dir_i, arith_i);
      end
      SHIFT_RUN: begin
        if (rem_gt_step) busy_o   = 1'b1;
        else             result_o = finish_val;
      end
      SHIFT_DONE: result_o = acc_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_serial_stage.sv
// Purpose : execute stage: logic ops, serial shifts, EX forwarding and the ex_mem register.
// Latency : logic 0 cycles (ex_mem next edge); shifts ceil(amount/SHIFT_STEP)-1 stall cycles.
// Backpressure: raises stallreq_o while shifting; mem_stall_i holds ex_mem and shift completion.
// Ports   : clk, rst, flush_i, mem_stall_i, id_ex (slave bundle) -> stallreq_o,
//           ex_wreg_o/ex_wd_o/ex_wdata_o (comb forwarding), mem_wreg_o/mem_wd_o/mem_wdata_o.
module ex_serial_stage
  import ex_serial_stage_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  ex_serial_stage_if.slave  id_ex,
  output logic              stallreq_o,
  output logic              ex_wreg_o,
  output logic [4:0]        ex_wd_o,
  output logic [31:0]       ex_wdata_o,
  output logic              mem_wreg_o,
  output logic [4:0]        mem_wd_o,
  output logic [31:0]       mem_wdata_o
);

  logic        is_shift;
  logic        shift_busy;
  logic [31:0] shift_res;
  logic [31:0] logic_res;
  wb_t         mem_q, mem_d;

  assign is_shift = (id_ex.alusel == EXE_RES_SHIFT) &&
                    ((id_ex.aluop == EXE_SLL_OP) || (id_ex.aluop == EXE_SRL_OP) ||
                     (id_ex.aluop == EXE_SRA_OP));

  ex_serial_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (is_shift),
    .dir_i    (id_ex.aluop != EXE_SLL_OP),
    .arith_i  (id_ex.aluop == EXE_SRA_OP),
    .amount_i (id_ex.reg1[4:0]),
    .value_i  (id_ex.reg2),
    .hold_i   (mem_stall_i),
    .abort_i  (flush_i),
    .busy_o   (shift_busy),
    .result_o (shift_res)
  );

  always_comb begin
    case (id_ex.aluop)
      EXE_OR_OP:  logic_res = id_ex.reg1 | id_ex.reg2;
      EXE_AND_OP: logic_res = id_ex.reg1 & id_ex.reg2;
      EXE_XOR_OP: logic_res = id_ex.reg1 ^ id_ex.reg2;
      EXE_NOR_OP: logic_res = ~(id_ex.reg1 | id_ex.reg2);
      EXE_LUI_OP: logic_res = id_ex.reg2;
      default:    logic_res = ZERO_WORD;
    endcase
  end

  always_comb begin
    case (id_ex.alusel)
      EXE_RES_LOGIC: ex_wdata_o = logic_res;
      EXE_RES_SHIFT: ex_wdata_o = shift_res;
      default:       ex_wdata_o = ZERO_WORD;
    endcase
  end

  assign stallreq_o = shift_busy;
  // A half-finished shift must never be forwarded as a valid write.
  assign ex_wreg_o  = id_ex.wreg & ~shift_busy;
  assign ex_wd_o    = id_ex.wd;

  always_comb begin
    if (flush_i)          mem_d = '0;
    else if (mem_stall_i) mem_d = mem_q;
    else if (stallreq_o)  mem_d = '0;
    else                  mem_d = '{wreg: ex_wreg_o, wd: ex_wd_o, wdata: ex_wdata_o};
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{wreg: 1'b0, wd: NOP_REG_ADDR, wdata: ZERO_WORD};
    else     mem_q <= mem_d;
  end

  assign mem_wreg_o  = mem_q.wreg;
  assign mem_wd_o    = mem_q.wd;
  assign mem_wdata_o = mem_q.wdata;

endmodule

// File: tb/tb_ex_serial_stage.sv
// Purpose : directed checks of ex_serial_stage at SHIFT_STEP=1 and SHIFT_STEP=8.
// Latency : inputs driven 1 time unit after posedge, comb outputs sampled at negedge.
// Backpressure: exercises mem_stall_i, flush_i and reset in the middle of a shift.
module tb_ex_serial_stage;
  import ex_serial_stage_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, mstall;
  always #5 clk = ~clk;

  ex_serial_stage_if if1 ();
  ex_serial_stage_if if8 ();

  logic        s1_stall, s1_ewreg, s1_mwreg, s8_stall, s8_ewreg, s8_mwreg;
  logic [4:0]  s1_ewd, s1_mwd, s8_ewd, s8_mwd;
  logic [31:0] s1_ewdata, s1_mwdata, s8_ewdata, s8_mwdata;

  ex_serial_stage #(.SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .mem_stall_i(mstall), .id_ex(if1),
    .stallreq_o(s1_stall), .ex_wreg_o(s1_ewreg), .ex_wd_o(s1_ewd), .ex_wdata_o(s1_ewdata),
    .mem_wreg_o(s1_mwreg), .mem_wd_o(s1_mwd), .mem_wdata_o(s1_mwdata)
  );

  ex_serial_stage #(.SHIFT_STEP(8)) dut8 (
    .clk(clk), .rst(rst), .flush_i(flush), .mem_stall_i(mstall), .id_ex(if8),
    .stallreq_o(s8_stall), .ex_wreg_o(s8_ewreg), .ex_wd_o(s8_ewd), .ex_wdata_o(s8_ewdata),
    .mem_wreg_o(s8_mwreg), .mem_wd_o(s8_mwd), .mem_wdata_o(s8_mwdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input aluop_t op, input alusel_t sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wreg);
    if1.aluop = op; if1.alusel = sel; if1.reg1 = a; if1.reg2 = b; if1.wd = wd; if1.wreg = wreg;
    if8.aluop = op; if8.alusel = sel; if8.reg1 = a; if8.reg2 = b; if8.wd = wd; if8.wreg = wreg;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  // Flush both instances back to IDLE with an empty id_ex bundle.
  task automatic clean;
    set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    tick;
  endtask

  task automatic run_shift(input string tag, input aluop_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp,
                           input int st1, input int st8);
    int c1, c8, cyc, nonbub;
    bit d1, d8, fin1, was1;
    logic [31:0] r1, r8;
    c1 = 0; c8 = 0; cyc = 0; nonbub = 0;
    d1 = 0; d8 = 0; r1 = '0; r8 = '0;
    clean;
    set_op(op, EXE_RES_SHIFT, a, b, 5'd7, 1'b1);
    while (!(d1 && d8) && cyc < 100) begin
      settle;
      fin1 = 0; was1 = 0;
      if (!d1) begin
        if (s1_stall) begin c1++; was1 = 1; end
        else begin r1 = s1_ewdata; d1 = 1; fin1 = 1; end
      end
      if (!d8) begin
        if (s8_stall) c8++;
        else begin r8 = s8_ewdata; d8 = 1; end
      end
      tick;
      if (was1 && s1_mwreg) nonbub++;
      if (fin1) begin
        chk({tag, " mem_wdata"}, s1_mwdata, exp);
        chk({tag, " mem_wreg"}, {31'b0, s1_mwreg}, 32'd1);
      end
      cyc++;
    end
    chk({tag, " finished s1"}, {31'b0, d1}, 32'd1);
    chk({tag, " finished s8"}, {31'b0, d8}, 32'd1);
    chk({tag, " result s1"}, r1, exp);
    chk({tag, " result s8"}, r8, exp);
    chk({tag, " stalls s1"}, c1, st1);
    chk({tag, " stalls s8"}, c8, st8);
    chk({tag, " bubbles"}, nonbub, 32'd0);
  endtask

  aluop_t      lop [6];
  alusel_t     lsel[6];
  logic [31:0] la  [6];
  logic [31:0] lb  [6];
  logic [31:0] lexp[6];

  initial begin
    int cnt;
    rst = 1'b1; flush = 1'b0; mstall = 1'b0;
    set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    tick; tick;
    settle;
    chk("reset mem_wreg", {31'b0, s1_mwreg}, 32'd0);
    chk("reset mem_wd", {27'b0, s1_mwd}, 32'd0);
    chk("reset mem_wdata", s1_mwdata, 32'h0);
    chk("reset stall", {31'b0, s1_stall}, 32'd0);
    rst = 1'b0;
    tick;

    // ori-style OR
    set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_1100, 32'h0000_0011, 5'd3, 1'b1);
    settle;
    chk("or wdata", s1_ewdata, 32'h0000_1111);
    chk("or stall", {31'b0, s1_stall}, 32'd0);
    chk("or ex_wreg", {31'b0, s1_ewreg}, 32'd1);
    chk("or ex_wd", {27'b0, s1_ewd}, 32'd3);
    tick;
    chk("or mem_wdata", s1_mwdata, 32'h0000_1111);
    chk("or mem_wd", {27'b0, s1_mwd}, 32'd3);
    chk("or mem_wreg", {31'b0, s1_mwreg}, 32'd1);

    lop[0] = EXE_AND_OP; lsel[0] = EXE_RES_LOGIC; la[0] = 32'hF0F0_1234; lb[0] = 32'hFF00_FF00; lexp[0] = 32'hF000_1200;
    lop[1] = EXE_XOR_OP; lsel[1] = EXE_RES_LOGIC; la[1] = 32'hF0F0_1234; lb[1] = 32'hFF00_FF00; lexp[1] = 32'h0FF0_ED34;
    lop[2] = EXE_NOR_OP; lsel[2] = EXE_RES_LOGIC; la[2] = 32'hF0F0_1234; lb[2] = 32'hFF00_FF00; lexp[2] = 32'h000F_00CB;
    lop[3] = EXE_LUI_OP; lsel[3] = EXE_RES_LOGIC; la[3] = 32'h1234_5678; lb[3] = 32'hABCD_0000; lexp[3] = 32'hABCD_0000;
    lop[4] = EXE_SLL_OP; lsel[4] = EXE_RES_LOGIC; la[4] = 32'h0000_0001; lb[4] = 32'h0000_0001; lexp[4] = 32'h0;
    lop[5] = EXE_OR_OP;  lsel[5] = EXE_RES_NOP;   la[5] = 32'h1111_0000; lb[5] = 32'h0000_2222; lexp[5] = 32'h0;
    for (int i = 0; i < 6; i++) begin
      set_op(lop[i], lsel[i], la[i], lb[i], 5'(i + 1), 1'b1);
      settle;
      chk($sformatf("logic%0d wdata", i), s1_ewdata, lexp[i]);
      chk($sformatf("logic%0d ex_wreg", i), {31'b0, s1_ewreg}, 32'd1);
      tick;
      chk($sformatf("logic%0d mem_wdata", i), s1_mwdata, lexp[i]);
      chk($sformatf("logic%0d mem_wd", i), {27'b0, s1_mwd}, 32'(i + 1));
    end

    run_shift("sll4",   EXE_SLL_OP, 32'd4,         32'h0000_000F, 32'h0000_00F0, 3,  0);
    run_shift("sra31",  EXE_SRA_OP, 32'd31,        32'h8000_0000, 32'hFFFF_FFFF, 30, 3);
    run_shift("srl31",  EXE_SRL_OP, 32'd31,        32'h8000_0000, 32'h0000_0001, 30, 3);
    run_shift("srl20",  EXE_SRL_OP, 32'd20,        32'hFFFF_FFFF, 32'h0000_0FFF, 19, 2);
    run_shift("sra0",   EXE_SRA_OP, 32'd0,         32'h8000_0000, 32'h8000_0000, 0,  0);
    run_shift("sra4",   EXE_SRA_OP, 32'd4,         32'hF000_0000, 32'hFF00_0000, 3,  0);
    run_shift("sllhi",  EXE_SLL_OP, 32'hFFFF_FFE3, 32'h0000_0001, 32'h0000_0008, 2,  0);

    // mem_stall_i on the completion cycle parks the result in DONE
    clean;
    set_op(EXE_SLL_OP, EXE_RES_SHIFT, 32'd5, 32'd1, 5'd6, 1'b1);
    cnt = 0;
    settle;
    while (s1_stall && cnt < 50) begin
      cnt++;
      tick;
      settle;
    end
    chk("mstall stalls", cnt, 32'd4);
    chk("mstall done wdata", s1_ewdata, 32'h0000_0020);
    mstall = 1'b1;
    tick;
    chk("mstall hold1 wreg", {31'b0, s1_mwreg}, 32'd0);
    settle;
    chk("mstall DONE wdata", s1_ewdata, 32'h0000_0020);
    chk("mstall DONE stall", {31'b0, s1_stall}, 32'd0);
    tick;
    chk("mstall hold2 wreg", {31'b0, s1_mwreg}, 32'd0);
    settle;
    chk("mstall DONE2 wdata", s1_ewdata, 32'h0000_0020);
    mstall = 1'b0;
    tick;
    chk("mstall release wdata", s1_mwdata, 32'h0000_0020);
    chk("mstall release wreg", {31'b0, s1_mwreg}, 32'd1);
    chk("mstall release wd", {27'b0, s1_mwd}, 32'd6);

    // flush in the middle of an SRL
    clean;
    set_op(EXE_SRL_OP, EXE_RES_SHIFT, 32'd10, 32'h0000_FFFF, 5'd9, 1'b1);
    tick; tick; tick;
    settle;
    chk("flush pre stall", {31'b0, s1_stall}, 32'd1);
    set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush mem_wreg", {31'b0, s1_mwreg}, 32'd0);
    chk("flush mem_wdata", s1_mwdata, 32'h0);
    settle;
    chk("flush stall", {31'b0, s1_stall}, 32'd0);

    // reset in the middle of an SLL, then a short shift to show rem was cleared
    set_op(EXE_SLL_OP, EXE_RES_SHIFT, 32'd20, 32'd3, 5'd4, 1'b1);
    tick; tick;
    settle;
    chk("rst pre stall", {31'b0, s1_stall}, 32'd1);
    set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    settle;
    chk("rst stall", {31'b0, s1_stall}, 32'd0);
    chk("rst mem_wreg", {31'b0, s1_mwreg}, 32'd0);
    chk("rst mem_wd", {27'b0, s1_mwd}, 32'd0);
    chk("rst mem_wdata", s1_mwdata, 32'h0);
    run_shift("sll2", EXE_SLL_OP, 32'd2, 32'd1, 32'h0000_0004, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
